pc_fetch_unit: RTL

//  Parametrised program counter and IF/ID stage register for the pipelined RV32I core.

---
 rtl/pc_fetch_if.sv | 23 ++
 rtl/pc_fetch_unit.sv | 50 +++++
 2 files changed

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: EX/hazard-side control into the fetch unit and the IF/ID state it returns.
interface pc_fetch_if #(parameter int WIDTH = 32);
    logic             stall;
    logic             redirect;
    logic             jalr;
    logic [WIDTH-1:0] ex_pc;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] immext;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_pc4;
    logic             id_valid;
    logic             misalign;
    logic             halted;
    modport master (
        output stall, redirect, jalr, ex_pc, rs1, immext,
        input  pc, id_pc, id_pc4, id_valid, misalign, halted
    );
    modport slave (
        input  stall, redirect, jalr, ex_pc, rs1, immext,
        output pc, id_pc, id_pc4, id_valid, misalign, halted
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus IF/ID register with redirect flush and sticky misalign halt.
module pc_fetch_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               IALIGN       = 4
) (
    input logic       clk,
    input logic       rst,
    pc_fetch_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t           state;
    logic [WIDTH-1:0] pc, id_pc, id_pc4, sum, target;
    logic             id_valid, misalign, bad;
    assign sum    = bus.jalr ? bus.rs1 + bus.immext : bus.ex_pc + bus.immext;
    // JALR clears bit 0 of the computed address before the alignment check
    assign target = {sum[WIDTH-1:1], sum[0] & ~bus.jalr};
    assign bad    = (IALIGN == 2) ? target[0] : |target[1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_VECTOR;
            id_pc    <= '0;
            id_pc4   <= '0;
            id_valid <= 1'b0;
            misalign <= 1'b0;
        end else if (state == RUN) begin
            if (bus.redirect) begin
                id_valid <= 1'b0;
                if (bad) begin
                    misalign <= 1'b1;
                    state    <= HALT;
                end else begin
                    pc <= target;
                end
            end else if (!bus.stall) begin
                id_pc    <= pc;
                id_pc4   <= pc + WIDTH'(4);
                id_valid <= 1'b1;
                pc       <= pc + WIDTH'(4);
            end
        end
    end
    assign bus.pc       = pc;
    assign bus.id_pc    = id_pc;
    assign bus.id_pc4   = id_pc4;
    assign bus.id_valid = id_valid;
    assign bus.misalign = misalign;
    assign bus.halted   = (state == HALT);
endmodule
